// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants, coordinate type and colour constants.
// Imported by the sync generator and by the downstream colour stage so both
// agree on the porch-offset coordinate space (visible area 144..783 x 35..514).
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 783;

    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 514;

    localparam int RGB_W = 12;
    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t BLACK = 12'h000;
    localparam rgb_t WHITE = 12'hFFF;
    localparam rgb_t GREEN = 12'h0F0;

    // Registered sync/visible decodes that travel together with the counters.
    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic bright;
    } sync_decode_t;

    // Inclusive range test on a coordinate.
    function automatic logic in_span(input coord_t value, input coord_t lo, input coord_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the pixel/colour logic and VGA pins.
// The generator drives through master; consumers read through slave.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   pix_en;
    coord_t hCount;
    coord_t vCount;
    logic   hSync;
    logic   vSync;
    logic   bright;
    logic   line_end;
    logic   frame_end;

    modport master (
        output pix_en,
        output hCount,
        output vCount,
        output hSync,
        output vSync,
        output bright,
        output line_end,
        output frame_end
    );

    modport slave (
        input pix_en,
        input hCount,
        input vCount,
        input hSync,
        input vSync,
        input bright,
        input line_end,
        input frame_end
    );

endinterface

// File: rtl/vga_sync_gen_tick.sv
// Pixel-rate enable generator: divides the system clock by CLK_DIV.
// CLK_DIV is legal from 1 to 16; with CLK_DIV=1 the enable is constantly high.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int DIV_W = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // Phase counter within the current pixel; wraps after the last clock of the pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign pix_en = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel enable, h/v counters, sync pulses, visible flag
// and line/frame end strobes. Sync and bright are registered from the next
// counter values so they line up with the counters presented on the same cycle.
module vga_sync_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_VIS_START = vga_timing_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_timing_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_VIS_START = vga_timing_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_timing_pkg::V_VIS_END
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    import vga_timing_pkg::*;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_SYNC_W = coord_t'(H_SYNC);
    localparam coord_t V_SYNC_W = coord_t'(V_SYNC);
    localparam coord_t H_VIS_LO = coord_t'(H_VIS_START);
    localparam coord_t H_VIS_HI = coord_t'(H_VIS_END);
    localparam coord_t V_VIS_LO = coord_t'(V_VIS_START);
    localparam coord_t V_VIS_HI = coord_t'(V_VIS_END);

    logic         pix_en;
    coord_t       h_q;
    coord_t       v_q;
    coord_t       h_next;
    coord_t       v_next;
    logic         last_pix;
    logic         last_line;
    sync_decode_t dec_next;
    sync_decode_t dec_q;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    assign last_pix  = (h_q == H_LAST);
    assign last_line = (v_q == V_LAST);

    // Upcoming coordinates: step once per pixel tick, wrapping the line and then the frame.
    always_comb begin
        h_next = h_q;
        v_next = v_q;
        if (pix_en) begin
            if (last_pix) begin
                h_next = '0;
                v_next = last_line ? '0 : v_q + 1'b1;
            end else begin
                h_next = h_q + 1'b1;
            end
        end
    end

    // Sync and visible decodes taken from the upcoming coordinates, so no lag behind the counters.
    always_comb begin
        dec_next        = '0;
        dec_next.h_sync = !(h_next < H_SYNC_W);
        dec_next.v_sync = !(v_next < V_SYNC_W);
        dec_next.bright = in_span(h_next, H_VIS_LO, H_VIS_HI) &&
                          in_span(v_next, V_VIS_LO, V_VIS_HI);
    end

    // Counter and decode registers; reset returns to the top-left corner with both syncs asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q   <= '0;
            v_q   <= '0;
            dec_q <= '0;
        end else begin
            h_q   <= h_next;
            v_q   <= v_next;
            dec_q <= dec_next;
        end
    end

    assign vga.pix_en    = pix_en;
    assign vga.hCount    = h_q;
    assign vga.vCount    = v_q;
    assign vga.hSync     = dec_q.h_sync;
    assign vga.vSync     = dec_q.v_sync;
    assign vga.bright    = dec_q.bright;
    assign vga.line_end  = pix_en && last_pix;
    assign vga.frame_end = pix_en && last_pix && last_line;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen. Four instances share one clock:
//   A: default timing, CLK_DIV=4 (random early resets, one mid-line reset)
//   B: default timing, CLK_DIV=1 (visible-window corner at line 35)
//   C: small timing,   CLK_DIV=1 (random resets, frame spacing)
//   D: small timing,   CLK_DIV=3 (random resets, frame spacing, window edges)
// Expected outputs come from the number of clocks since the last reset edge:
// pixel = t / div, hCount = pixel % H_TOTAL, vCount = (pixel / H_TOTAL) % V_TOTAL.
module tb_vga_sync_gen;

    typedef struct {
        int div;
        int hT;
        int hS;
        int hVs;
        int hVe;
        int vT;
        int vS;
        int vVs;
        int vVe;
    } timing_t;

    typedef struct {
        int   h;
        int   v;
        logic val;
    } probe_t;

    localparam int NUM_CYCLES = 45000;

    timing_t cfgA = '{4, 800, 96, 144, 783, 525, 2, 35, 514};
    timing_t cfgB = '{1, 800, 96, 144, 783, 525, 2, 35, 514};
    timing_t cfgC = '{1, 20, 3, 5, 17, 10, 2, 3, 8};
    timing_t cfgD = '{3, 20, 3, 5, 17, 10, 2, 3, 8};

    probe_t brightProbeB[5] = '{'{143, 35, 1'b0}, '{144, 35, 1'b1}, '{144, 34, 1'b0},
                                '{783, 35, 1'b1}, '{784, 35, 1'b0}};
    probe_t brightProbeD[6] = '{'{17, 8, 1'b1}, '{18, 8, 1'b0}, '{5, 9, 1'b0},
                                '{4, 3, 1'b0}, '{5, 3, 1'b1}, '{5, 2, 1'b0}};

    logic clk = 1'b0;
    logic rstA, rstB, rstC, rstD;

    vga_sync_gen_if ifA ();
    vga_sync_gen_if ifB ();
    vga_sync_gen_if ifC ();
    vga_sync_gen_if ifD ();

    vga_sync_gen #(.CLK_DIV(4)) dutA (.clk(clk), .rst(rstA), .vga(ifA));
    vga_sync_gen #(.CLK_DIV(1)) dutB (.clk(clk), .rst(rstB), .vga(ifB));
    vga_sync_gen #(
        .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(17),
        .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8)
    ) dutC (.clk(clk), .rst(rstC), .vga(ifC));
    vga_sync_gen #(
        .CLK_DIV(3), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(17),
        .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8)
    ) dutD (.clk(clk), .rst(rstD), .vga(ifD));

    always #5 clk = ~clk;

    logic [25:0] obsA, obsB, obsC, obsD;
    assign obsA = {ifA.pix_en, ifA.hCount, ifA.vCount, ifA.hSync, ifA.vSync, ifA.bright, ifA.line_end, ifA.frame_end};
    assign obsB = {ifB.pix_en, ifB.hCount, ifB.vCount, ifB.hSync, ifB.vSync, ifB.bright, ifB.line_end, ifB.frame_end};
    assign obsC = {ifC.pix_en, ifC.hCount, ifC.vCount, ifC.hSync, ifC.vSync, ifC.bright, ifC.line_end, ifC.frame_end};
    assign obsD = {ifD.pix_en, ifD.hCount, ifD.vCount, ifD.hSync, ifD.vSync, ifD.bright, ifD.line_end, ifD.frame_end};

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int tA = 0, tB = 0, tC = 0, tD = 0;
    int rstLeftA = 0, rstLeftC = 0, rstLeftD = 0;
    int sinceRstA = 0, sinceRstD = 0;
    logic waitPixA = 1'b0, waitPixD = 1'b0;
    logic midDone = 1'b0, midPending = 1'b0;
    logic reachedA = 1'b0;
    int lastFeC = -1, lastFeD = -1;
    int spacingC = 0, spacingD = 0;

    // Compare one observed value with its expected value and report a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, observed, expected);
        end
    endtask

    // Expected output vector for a given clock count since the last reset edge.
    function automatic logic [25:0] expectedOut(input timing_t c, input int t);
        int p, h, v;
        logic pe, le, fe, hs, vs, br;
        p  = t / c.div;
        h  = p % c.hT;
        v  = (p / c.hT) % c.vT;
        pe = ((t % c.div) == c.div - 1);
        le = pe && (h == c.hT - 1);
        fe = le && (v == c.vT - 1);
        hs = (h >= c.hS);
        vs = (v >= c.vS);
        br = (h >= c.hVs) && (h <= c.hVe) && (v >= c.vVs) && (v <= c.vVe);
        return {pe, h[9:0], v[9:0], hs, vs, br, le, fe};
    endfunction

    // Track clocks since reset for each instance after every rising edge.
    task automatic advanceModel();
        tA = rstA ? 0 : tA + 1;
        tB = rstB ? 0 : tB + 1;
        tC = rstC ? 0 : tC + 1;
        tD = rstD ? 0 : tD + 1;
        if (rstA) begin sinceRstA = 0; waitPixA = 1'b1; end else sinceRstA++;
        if (rstD) begin sinceRstD = 0; waitPixD = 1'b1; end else sinceRstD++;
        if (rstC) lastFeC = -1;
        if (rstD) lastFeD = -1;
    endtask

    // Decide reset levels for the next rising edge.
    task automatic applyStimulus();
        if (cyc < 2) begin
            rstA = 1'b1; rstB = 1'b1; rstC = 1'b1; rstD = 1'b1;
        end else begin
            rstB = 1'b0;
            if (rstLeftA == 0) begin
                if (cyc < 2000 && $urandom_range(299, 0) == 0) begin
                    rstLeftA = int'($urandom_range(3, 1));
                end else if (cyc >= 2000 && !midDone && (tA % 3200) == 1602) begin
                    // hCount=400 with the pixel phase at 2: single-clock reset mid-line.
                    rstLeftA   = 1;
                    midDone    = 1'b1;
                    midPending = 1'b1;
                end
            end
            if (rstLeftC == 0 && $urandom_range(1499, 0) == 0) rstLeftC = int'($urandom_range(3, 1));
            if (rstLeftD == 0 && $urandom_range(1499, 0) == 0) rstLeftD = int'($urandom_range(3, 1));
            rstA = (rstLeftA > 0);
            rstC = (rstLeftC > 0);
            rstD = (rstLeftD > 0);
            if (rstLeftA > 0) rstLeftA--;
            if (rstLeftC > 0) rstLeftC--;
            if (rstLeftD > 0) rstLeftD--;
        end
    endtask

    // All per-cycle comparisons, taken on the falling edge.
    task automatic checkCycle();
        int pA, pB, hB, vB, pD, hD, vD;
        checkOutput("A_outputs", obsA, expectedOut(cfgA, tA));
        checkOutput("B_outputs", obsB, expectedOut(cfgB, tB));
        checkOutput("C_outputs", obsC, expectedOut(cfgC, tC));
        checkOutput("D_outputs", obsD, expectedOut(cfgD, tD));

        if (midPending) begin
            checkOutput("A_reset_state_after_midline_rst", obsA, 64'd0);
            midPending = 1'b0;
        end

        // Cycle index of the first pixel enable after reset (cycle 0 follows the reset edge).
        if (waitPixA) begin
            if (ifA.pix_en) begin
                checkOutput("A_first_pix_en_cycle", sinceRstA, 3);
                waitPixA = 1'b0;
            end else if (sinceRstA > 10) begin
                checkOutput("A_first_pix_en_timeout", sinceRstA, 3);
                waitPixA = 1'b0;
            end
        end
        if (waitPixD) begin
            if (ifD.pix_en) begin
                checkOutput("D_first_pix_en_cycle", sinceRstD, 2);
                waitPixD = 1'b0;
            end else if (sinceRstD > 8) begin
                checkOutput("D_first_pix_en_timeout", sinceRstD, 2);
                waitPixD = 1'b0;
            end
        end

        pA = tA / 4;
        if (pA == 3 * 800 + 95) checkOutput("A_hSync_at_95", ifA.hSync, 0);
        if (pA == 3 * 800 + 96) checkOutput("A_hSync_at_96", ifA.hSync, 1);
        if (pA == 1 * 800 + 10) checkOutput("A_vSync_at_v1", ifA.vSync, 0);
        if (pA == 2 * 800 + 10) checkOutput("A_vSync_at_v2", ifA.vSync, 1);
        if (tA == 35198) checkOutput("A_line_end_before_last_clk", ifA.line_end, 0);
        if (tA == 35199) begin
            checkOutput("A_line_end_at_799_10", ifA.line_end, 1);
            checkOutput("A_hCount_at_line_end", ifA.hCount, 799);
            checkOutput("A_frame_end_mid_frame", ifA.frame_end, 0);
        end
        if (tA == 35200) begin
            checkOutput("A_line_end_one_clk", ifA.line_end, 0);
            checkOutput("A_hCount_wrap", ifA.hCount, 0);
            checkOutput("A_vCount_step_to_11", ifA.vCount, 11);
            checkOutput("A_frame_end_stays_low", ifA.frame_end, 0);
            reachedA = 1'b1;
        end

        pB = tB;
        hB = pB % 800;
        vB = (pB / 800) % 525;
        foreach (brightProbeB[i]) begin
            if (hB == brightProbeB[i].h && vB == brightProbeB[i].v)
                checkOutput($sformatf("B_bright_at_%0d_%0d", hB, vB), ifB.bright, brightProbeB[i].val);
        end

        pD = tD / 3;
        hD = pD % 20;
        vD = (pD / 20) % 10;
        foreach (brightProbeD[i]) begin
            if (hD == brightProbeD[i].h && vD == brightProbeD[i].v)
                checkOutput($sformatf("D_bright_at_%0d_%0d", hD, vD), ifD.bright, brightProbeD[i].val);
        end
        if (hD == 2 && vD == 5) checkOutput("D_hSync_last_low", ifD.hSync, 0);
        if (hD == 3 && vD == 5) checkOutput("D_hSync_first_high", ifD.hSync, 1);
        if (tD >= 3 && (pD % 200) == 0 && (tD % 3) == 0) begin
            checkOutput("D_vCount_frame_wrap", ifD.vCount, 0);
            checkOutput("D_vSync_after_wrap", ifD.vSync, 0);
        end

        if (ifC.frame_end) begin
            if (lastFeC >= 0) begin
                checkOutput("C_frame_spacing", cyc - lastFeC, 200);
                spacingC++;
            end
            lastFeC = cyc;
        end
        if (ifD.frame_end) begin
            if (lastFeD >= 0) begin
                checkOutput("D_frame_spacing", cyc - lastFeD, 600);
                spacingD++;
            end
            lastFeD = cyc;
        end
    endtask

    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        rstC = 1'b1;
        rstD = 1'b1;
        for (int c = 0; c < NUM_CYCLES; c++) begin
            cyc = c;
            @(posedge clk);
            advanceModel();
            @(negedge clk);
            checkCycle();
            applyStimulus();
        end
        checkOutput("A_reached_line_11", reachedA, 1);
        checkOutput("C_frame_spacings_measured", (spacingC > 0), 1);
        checkOutput("D_frame_spacings_measured", (spacingD > 0), 1);
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
